// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: turns hazard, branch-flush and memory-wait requests into
// per-stage register enables/flushes, and keeps saturating performance counters.
module pipeline_stall_controller #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nop,
  input  logic             branch_taken_execute,
  input  logic             mem_busy,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_flush,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_count
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  // The first bubble cycle is spent in RUN, so STALL only covers the remaining ones.
  localparam int          RELOAD_INT   = (STALL_CYCLES > 1) ? (STALL_CYCLES - 2) : 0;
  localparam logic [3:0]  STALL_RELOAD = RELOAD_INT[3:0];

  state_t     state_r, next_state_s;
  logic [3:0] remaining_r, next_remaining_s;
  logic       freeze_s, flush_s, stall_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (&value) begin
      return value;
    end else begin
      return value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Event decode in priority order: freeze, then flush, then stall.
  always_comb begin
    freeze_s = mem_busy;
    flush_s  = !mem_busy && branch_taken_execute;
    stall_s  = !mem_busy && !branch_taken_execute && ((state_r == STALL) || nop);
  end

  // State register and bubble down-counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= RUN;
      remaining_r <= 4'd0;
    end else begin
      state_r     <= next_state_s;
      remaining_r <= next_remaining_s;
    end
  end

  // Next-state logic; a frozen cycle holds everything so it consumes no bubble cycle.
  always_comb begin
    next_state_s     = state_r;
    next_remaining_s = remaining_r;
    if (freeze_s) begin
      next_state_s     = state_r;
      next_remaining_s = remaining_r;
    end else if (flush_s) begin
      next_state_s     = RUN;
      next_remaining_s = 4'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (nop && (STALL_CYCLES > 1)) begin
            next_state_s     = STALL;
            next_remaining_s = STALL_RELOAD;
          end else begin
            next_state_s     = RUN;
            next_remaining_s = remaining_r;
          end
        end
        STALL: begin
          if (remaining_r == 4'd0) begin
            next_state_s = RUN;
          end else begin
            next_remaining_s = remaining_r - 4'd1;
          end
        end
        default: begin
          next_state_s     = RUN;
          next_remaining_s = 4'd0;
        end
      endcase
    end
  end

  // Output decode; reset forces every enable and flush low regardless of inputs.
  always_comb begin
    pc_enable     = 1'b0;
    if_id_enable  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b0;
    mem_wb_enable = 1'b0;
    stall_active  = rst && (state_r == STALL);
    if (!rst || freeze_s) begin
      pc_enable = 1'b0;
    end else if (flush_s) begin
      pc_enable     = 1'b1;
      if_id_enable  = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_enable  = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_enable = 1'b1;
      mem_wb_enable = 1'b1;
    end else if (stall_s) begin
      id_ex_enable  = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_enable = 1'b1;
      mem_wb_enable = 1'b1;
    end else begin
      pc_enable     = 1'b1;
      if_id_enable  = 1'b1;
      id_ex_enable  = 1'b1;
      ex_mem_enable = 1'b1;
      mem_wb_enable = 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count  <= {CNT_W{1'b0}};
      flush_count  <= {CNT_W{1'b0}};
      freeze_count <= {CNT_W{1'b0}};
    end else begin
      stall_count  <= stall_s  ? sat_inc(stall_count)  : stall_count;
      flush_count  <= flush_s  ? sat_inc(flush_count)  : flush_count;
      freeze_count <= freeze_s ? sat_inc(freeze_count) : freeze_count;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: three controller instances (1-cycle bubble, 3-cycle bubble, 4-bit
// counters) share one stimulus stream; each phase checks the relevant instance.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst, nop, branch_taken_execute, mem_busy;
  int   n_checks = 0;
  int   n_fails  = 0;

  // Output vector order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en
  localparam logic [6:0] O_OFF    = 7'b0000000;
  localparam logic [6:0] O_NORMAL = 7'b1101011;
  localparam logic [6:0] O_STALL  = 7'b0001111;
  localparam logic [6:0] O_FLUSH  = 7'b1111111;

  logic [6:0]  o1, o3, os;
  logic        pe1, ie1, if1, de1, df1, ee1, we1, sa1;
  logic        pe3, ie3, if3, de3, df3, ee3, we3, sa3;
  logic        pes, ies, ifs, des, dfs, ees, wes, sas;
  logic [15:0] sc1, fc1, zc1, sc3, fc3, zc3;
  logic [3:0]  scs, fcs, zcs;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .nop(nop), .branch_taken_execute(branch_taken_execute),
    .mem_busy(mem_busy), .pc_enable(pe1), .if_id_enable(ie1), .if_id_flush(if1),
    .id_ex_enable(de1), .id_ex_flush(df1), .ex_mem_enable(ee1), .mem_wb_enable(we1),
    .stall_active(sa1), .stall_count(sc1), .flush_count(fc1), .freeze_count(zc1));

  pipeline_stall_controller #(.STALL_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .nop(nop), .branch_taken_execute(branch_taken_execute),
    .mem_busy(mem_busy), .pc_enable(pe3), .if_id_enable(ie3), .if_id_flush(if3),
    .id_ex_enable(de3), .id_ex_flush(df3), .ex_mem_enable(ee3), .mem_wb_enable(we3),
    .stall_active(sa3), .stall_count(sc3), .flush_count(fc3), .freeze_count(zc3));

  pipeline_stall_controller #(.STALL_CYCLES(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .nop(nop), .branch_taken_execute(branch_taken_execute),
    .mem_busy(mem_busy), .pc_enable(pes), .if_id_enable(ies), .if_id_flush(ifs),
    .id_ex_enable(des), .id_ex_flush(dfs), .ex_mem_enable(ees), .mem_wb_enable(wes),
    .stall_active(sas), .stall_count(scs), .flush_count(fcs), .freeze_count(zcs));

  assign o1 = {pe1, ie1, if1, de1, df1, ee1, we1};
  assign o3 = {pe3, ie3, if3, de3, df3, ee3, we3};
  assign os = {pes, ies, ifs, des, dfs, ees, wes};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic n, input logic b, input logic m);
    nop = n;
    branch_taken_execute = b;
    mem_busy = m;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // Reset with requests asserted
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1);
    check("rst_out1", {25'd0, o1}, {25'd0, O_OFF});
    check("rst_out3", {25'd0, o3}, {25'd0, O_OFF});
    tick();
    drive(1'b1, 1'b1, 1'b1);
    check("rst_out1_b", {25'd0, o1}, {25'd0, O_OFF});
    check("rst_sa3", {31'd0, sa3}, 32'd0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    check("post_rst_out1", {25'd0, o1}, {25'd0, O_NORMAL});
    check("post_rst_out3", {25'd0, o3}, {25'd0, O_NORMAL});
    check("post_rst_outs", {25'd0, os}, {25'd0, O_NORMAL});
    check("post_rst_sa", {29'd0, sa1, sa3, sas}, 32'd0);
    check("post_rst_cnt1", {sc1, fc1 | zc1}, 32'd0);
    check("post_rst_cnt3", {sc3, fc3 | zc3}, 32'd0);
    check("post_rst_cnts", {20'd0, scs, fcs, zcs}, 32'd0);

    // Single-cycle bubble
    drive(1'b1, 1'b0, 1'b0);
    check("sb_c1_out", {25'd0, o1}, {25'd0, O_STALL});
    check("sb_c1_sa", {31'd0, sa1}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check("sb_c2_out", {25'd0, o1}, {25'd0, O_NORMAL});
    check("sb_c2_sa", {31'd0, sa1}, 32'd0);
    check("sb_stall_cnt", {16'd0, sc1}, 32'd1);

    // Multi-cycle bubble
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    check("mb_c1_out", {25'd0, o3}, {25'd0, O_STALL});
    check("mb_c1_sa", {31'd0, sa3}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check("mb_c2_out", {25'd0, o3}, {25'd0, O_STALL});
    check("mb_c2_sa", {31'd0, sa3}, 32'd1);
    tick();
    check("mb_c3_out", {25'd0, o3}, {25'd0, O_STALL});
    check("mb_c3_sa", {31'd0, sa3}, 32'd1);
    tick();
    check("mb_c4_out", {25'd0, o3}, {25'd0, O_NORMAL});
    check("mb_c4_sa", {31'd0, sa3}, 32'd0);
    check("mb_stall_cnt", {16'd0, sc3}, 32'd3);

    // Held nop re-starts a bubble on the first RUN cycle
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("resample_out", {25'd0, o3}, {25'd0, O_STALL});
    check("resample_sa", {31'd0, sa3}, 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check("resample_sa2", {31'd0, sa3}, 32'd1);

    // Reset mid-stall
    rst = 1'b0;
    #1;
    check("midrst_out", {25'd0, o3}, {25'd0, O_OFF});
    check("midrst_sa", {31'd0, sa3}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_after_out", {25'd0, o3}, {25'd0, O_NORMAL});
    check("midrst_after_sa", {31'd0, sa3}, 32'd0);

    // Freeze inside a bubble
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    check("fz_c1_out", {25'd0, o3}, {25'd0, O_STALL});
    tick();
    drive(1'b0, 1'b0, 1'b1);
    check("fz_f1_out", {25'd0, o3}, {25'd0, O_OFF});
    check("fz_f1_sa", {31'd0, sa3}, 32'd1);
    tick();
    check("fz_f2_out", {25'd0, o3}, {25'd0, O_OFF});
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check("fz_c2_out", {25'd0, o3}, {25'd0, O_STALL});
    check("fz_c2_sa", {31'd0, sa3}, 32'd1);
    tick();
    check("fz_c3_out", {25'd0, o3}, {25'd0, O_STALL});
    tick();
    check("fz_done_out", {25'd0, o3}, {25'd0, O_NORMAL});
    check("fz_freeze_cnt", {16'd0, zc3}, 32'd2);
    check("fz_stall_cnt", {16'd0, sc3}, 32'd3);

    // Flush beats stall, in RUN then in STALL
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    check("fl_run_out", {25'd0, o3}, {25'd0, O_FLUSH});
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check("fl_run_next", {25'd0, o3}, {25'd0, O_NORMAL});
    check("fl_flush_cnt", {16'd0, fc3}, 32'd1);
    check("fl_stall_cnt", {16'd0, sc3}, 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    check("fl_stall_sa", {31'd0, sa3}, 32'd1);
    check("fl_stall_out", {25'd0, o3}, {25'd0, O_FLUSH});
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check("fl_stall_next_sa", {31'd0, sa3}, 32'd0);
    check("fl_stall_next_out", {25'd0, o3}, {25'd0, O_NORMAL});
    check("fl_flush_cnt2", {16'd0, fc3}, 32'd2);
    check("fl_stall_cnt2", {16'd0, sc3}, 32'd1);

    // Saturation of a 4-bit counter
    do_reset();
    drive(1'b0, 1'b0, 1'b1);
    check("sat_out", {25'd0, os}, {25'd0, O_OFF});
    for (int i = 0; i < 20; i++) tick();
    drive(1'b0, 1'b0, 1'b0);
    check("sat_freeze_cnt", {28'd0, zcs}, 32'd15);
    check("sat_wide_cnt", {16'd0, zc1}, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
